// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter that shares one synchronous FIFO write port between NREQ streams.
// A grant is held until the packet's last beat or MAX_BURST beats, then one IDLE cycle re-arbitrates.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_din,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state;
    logic [GW-1:0]     last_grant;
    logic [CW-1:0]     beat_cnt;
    logic [GW-1:0]     pick;
    logic              pick_found;
    logic              xfer;
    logic              burst_end;
    logic [DWIDTH-1:0] lane [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane[i] = req_data[i*DWIDTH +: DWIDTH];
        end
    end

    // Rotating priority: the requester just after the previous grantee is searched first.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!pick_found && req_valid[GW'(idx)]) begin
                pick_found = 1'b1;
                pick       = GW'(idx);
            end
        end
    end

    // The FIFO full flag gates ready in the same cycle, so a write never lands on a full FIFO.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        xfer       = 1'b0;
        if (state == BURST) begin
            req_ready[grant_id] = !fifo_full;
            xfer                = req_valid[grant_id] && !fifo_full;
        end
        if (xfer) begin
            fifo_wr_en = 1'b1;
            fifo_din   = lane[grant_id];
        end
    end

    assign burst_end = req_last[grant_id] || (beat_cnt == CW'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            beat_cnt   <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (burst_end) begin
                            last_grant <= grant_id;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle comparison against a transaction-level
// ownership model, plus directed grant/burst-length checks and a per-requester ordering scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int MB   = 8;
    localparam int GW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic [GW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // Source beats per requester: {last, data}
    logic [DW:0]      src_q [NREQ][$];
    logic [DW-1:0]    ref_q [NREQ][$];
    logic [NREQ-1:0]  gap;
    logic             full_in;

    // Ownership model: owner = -1 means nobody holds the port
    int m_owner, m_prev, m_taken, m_shown;

    logic [NREQ-1:0]        exp_ready, cap_hs;
    logic                   exp_wr, exp_busy;
    logic [DW-1:0]          exp_din;
    logic [GW-1:0]          exp_gid;
    logic [NREQ+DW+GW+1:0]  exp_v, obs, now_v;

    int            g_grants[$];
    int            g_runs[$];
    logic [DW-1:0] g_wdata[$];
    int            g_busy, g_full_wr;
    logic          was_busy;

    int checks = 0;
    int passes = 0;

    task automatic model_reset();
        m_owner = -1;
        m_prev  = NREQ - 1;
        m_taken = 0;
        m_shown = 0;
    endtask

    task automatic clear_log();
        g_grants.delete();
        g_runs.delete();
        g_wdata.delete();
        g_busy    = 0;
        g_full_wr = 0;
        was_busy  = 1'b0;
    endtask

    function automatic bit busy_left();
        bit r;
        r = (m_owner >= 0);
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) r = 1'b1;
        return r;
    endfunction

    function automatic string fmt_q(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic pulse_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        full_in   = 1'b0;
        gap       = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            ref_q[i].delete();
        end
        model_reset();
        clear_log();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, settle, and compute the model's expectation for this cycle.
    task automatic drive_cycle();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0 && !gap[i]) begin
                req_valid[i]            = 1'b1;
                req_last[i]             = src_q[i][0][DW];
                req_data[i*DW +: DW]    = src_q[i][0][DW-1:0];
            end else begin
                req_valid[i]            = 1'b0;
                req_last[i]             = 1'($urandom);
                req_data[i*DW +: DW]    = DW'($urandom);
            end
        end
        fifo_full = full_in;
        #1;
        exp_busy  = (m_owner >= 0);
        exp_gid   = GW'(m_shown);
        exp_ready = (m_owner >= 0 && !full_in) ? NREQ'(1 << m_owner) : '0;
        exp_wr    = (m_owner >= 0) ? (req_valid[m_owner] && !full_in) : 1'b0;
        exp_din   = exp_wr ? req_data[m_owner*DW +: DW] : '0;
        exp_v     = {exp_ready, exp_wr, exp_din, exp_gid, exp_busy};
        obs       = {req_ready, fifo_wr_en, fifo_din, grant_id, busy};
        cap_hs    = req_ready & req_valid;
        if (busy && !was_busy) begin
            g_grants.push_back(int'(grant_id));
            g_runs.push_back(0);
        end
        if (busy) g_busy++;
        if (fifo_wr_en) begin
            g_wdata.push_back(fifo_din);
            if (g_runs.size() > 0) g_runs[g_runs.size()-1]++;
        end
        if (fifo_wr_en && fifo_full) g_full_wr++;
        was_busy = busy;
    endtask

    // Advance across the clock edge: update ownership from the arbitration rules and pop accepted beats.
    task automatic end_cycle();
        @(posedge clk);
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_prev + k) % NREQ;
                if (m_owner < 0 && req_valid[c]) begin
                    m_owner = c;
                    m_shown = c;
                    m_taken = 0;
                end
            end
        end else if (exp_wr) begin
            m_taken++;
            if (req_last[m_owner] || m_taken == MB) begin
                m_prev  = m_owner;
                m_owner = -1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (cap_hs[i]) void'(src_q[i].pop_front());
        end
        #1;
    endtask

    task automatic push_packet(input int id, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++) begin
            src_q[id].push_back({b == len - 1, base + DW'(b)});
            ref_q[id].push_back(base + DW'(b));
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '0;
        req_data  = '1;
        fifo_full = 1'b0;
        full_in   = 1'b0;
        gap       = '0;
        model_reset();
        clear_log();
        #2;
        now_v = {req_ready, fifo_wr_en, fifo_din, grant_id, busy};
        checks++;
        if (now_v !== '0) $display("[TB] FAIL reset_outputs: got %h, want 0", now_v);
        else passes++;
        @(posedge clk);
        #1;
        now_v = {req_ready, fifo_wr_en, fifo_din, grant_id, busy};
        checks++;
        if (now_v !== '0) $display("[TB] FAIL reset_held_edge: got %h, want 0", now_v);
        else passes++;
        req_valid = '0;
        rst       = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL reset_idle cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
    endtask

    task automatic test_single_packet();
        pulse_reset();
        push_packet(0, 3, 16'hA001);
        for (int n = 0; n < 20 && busy_left(); n++) begin
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL single_outputs cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        checks++;
        if (busy_left()) $display("[TB] FAIL single_drain: packet still pending, want drained");
        else passes++;
        checks++;
        if (g_grants.size() != 1 || g_grants[0] != 0 || g_runs[0] != 3 || g_busy != 3)
            $display("[TB] FAIL single_burst: grants %s busy %0d, want grant 0, 3 writes, busy 3", fmt_q(g_grants), g_busy);
        else passes++;
        checks++;
        if (g_wdata.size() != 3 || g_wdata[0] !== 16'hA001 || g_wdata[1] !== 16'hA002 || g_wdata[2] !== 16'hA003)
            $display("[TB] FAIL single_data: got %0d writes, want A001 A002 A003", g_wdata.size());
        else passes++;
    endtask

    task automatic test_two_requesters();
        pulse_reset();
        push_packet(0, 2, 16'hB001);
        push_packet(0, 2, 16'hB011);
        push_packet(2, 2, 16'hC001);
        for (int n = 0; n < 40 && busy_left(); n++) begin
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL two_outputs cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        checks++;
        if (busy_left()) $display("[TB] FAIL two_drain: packets still pending, want drained");
        else passes++;
        checks++;
        if (g_grants.size() != 3 || g_grants[0] != 0 || g_grants[1] != 2 || g_grants[2] != 0)
            $display("[TB] FAIL two_grant_order: got %s, want 0 2 0", fmt_q(g_grants));
        else passes++;
        checks++;
        if (g_runs.size() != 3 || g_runs[0] != 2 || g_runs[1] != 2 || g_runs[2] != 2)
            $display("[TB] FAIL two_run_lengths: got %s, want 2 2 2", fmt_q(g_runs));
        else passes++;
    endtask

    task automatic test_max_burst();
        pulse_reset();
        push_packet(1, 10, 16'h1100);
        for (int n = 0; n < 40 && busy_left(); n++) begin
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL maxburst_outputs cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        checks++;
        if (busy_left()) $display("[TB] FAIL maxburst_drain: packet still pending, want drained");
        else passes++;
        checks++;
        if (g_grants.size() != 2 || g_grants[0] != 1 || g_grants[1] != 1 || g_runs[0] != 8 || g_runs[1] != 2)
            $display("[TB] FAIL maxburst_split: grants %s runs %s, want grants 1 1 runs 8 2", fmt_q(g_grants), fmt_q(g_runs));
        else passes++;
    endtask

    task automatic test_fifo_full();
        pulse_reset();
        push_packet(0, 6, 16'hF000);
        for (int n = 0; n < 40 && busy_left(); n++) begin
            full_in = (n >= 3 && n <= 5);
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL full_outputs cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        full_in = 1'b0;
        checks++;
        if (busy_left()) $display("[TB] FAIL full_drain: packet still pending, want drained");
        else passes++;
        checks++;
        if (g_full_wr != 0 || g_runs.size() != 1 || g_runs[0] != 6)
            $display("[TB] FAIL full_writes: writes-while-full %0d runs %s, want 0 and 6", g_full_wr, fmt_q(g_runs));
        else passes++;
        checks++;
        if (g_wdata.size() != 6 || g_wdata[3] !== 16'hF003 || g_wdata[5] !== 16'hF005)
            $display("[TB] FAIL full_data: got %0d writes, want F000..F005 in order", g_wdata.size());
        else passes++;
    endtask

    task automatic test_valid_gap();
        pulse_reset();
        push_packet(0, 4, 16'h0A00);
        push_packet(3, 1, 16'h3D00);
        for (int n = 0; n < 40 && busy_left(); n++) begin
            gap[0] = (n == 3 || n == 4);
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL gap_outputs cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        gap = '0;
        checks++;
        if (busy_left()) $display("[TB] FAIL gap_drain: packets still pending, want drained");
        else passes++;
        checks++;
        if (g_grants.size() != 2 || g_grants[0] != 0 || g_grants[1] != 3 || g_runs[0] != 4 || g_runs[1] != 1)
            $display("[TB] FAIL gap_grants: grants %s runs %s, want grants 0 3 runs 4 1", fmt_q(g_grants), fmt_q(g_runs));
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        pulse_reset();
        push_packet(2, 4, 16'h2E00);
        for (int n = 0; n < 3; n++) begin
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL midreset_pre cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            if (n < 2) end_cycle();
        end
        rst = 1'b1;
        #1;
        now_v = {req_ready, fifo_wr_en, fifo_din, grant_id, busy};
        checks++;
        if (now_v !== '0) $display("[TB] FAIL midreset_outputs: got %h, want 0", now_v);
        else passes++;
        src_q[2].delete();
        model_reset();
        clear_log();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_packet(0, 10, 16'h0B00);
        push_packet(2, 2, 16'h2F00);
        for (int n = 0; n < 60 && busy_left(); n++) begin
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL midreset_post cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        checks++;
        if (busy_left()) $display("[TB] FAIL midreset_drain: packets still pending, want drained");
        else passes++;
        checks++;
        if (g_grants.size() != 3 || g_grants[0] != 0 || g_grants[1] != 2 || g_grants[2] != 0 ||
            g_runs[0] != 8 || g_runs[1] != 2 || g_runs[2] != 2)
            $display("[TB] FAIL midreset_grants: grants %s runs %s, want grants 0 2 0 runs 8 2 2", fmt_q(g_grants), fmt_q(g_runs));
        else passes++;
    endtask

    task automatic test_random();
        int bad;
        int id;
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            int seq;
            seq = 0;
            for (int p = 0; p < 3; p++) begin
                int len;
                len = $urandom_range(1, 12);
                push_packet(i, len, {2'(i), 14'(seq)});
                seq += len;
            end
        end
        for (int n = 0; n < 3000 && busy_left(); n++) begin
            for (int i = 0; i < NREQ; i++) gap[i] = ($urandom_range(0, 4) == 0);
            full_in = ($urandom_range(0, 3) == 0);
            drive_cycle();
            checks++;
            if (obs !== exp_v) $display("[TB] FAIL random_outputs cycle %0d: got %h, want %h", n, obs, exp_v);
            else passes++;
            end_cycle();
        end
        gap     = '0;
        full_in = 1'b0;
        checks++;
        if (busy_left()) $display("[TB] FAIL random_drain: traffic still pending after cycle budget");
        else passes++;
        checks++;
        if (g_full_wr != 0) $display("[TB] FAIL random_full_guard: %0d writes while full, want 0", g_full_wr);
        else passes++;
        bad = 0;
        foreach (g_wdata[k]) begin
            id = int'(g_wdata[k][DW-1:DW-2]);
            if (ref_q[id].size() == 0 || ref_q[id][0] !== g_wdata[k]) bad++;
            else void'(ref_q[id].pop_front());
        end
        for (int i = 0; i < NREQ; i++) bad += ref_q[i].size();
        checks++;
        if (bad != 0) $display("[TB] FAIL random_order: %0d out-of-order or missing beats, want 0", bad);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_two_requesters();
        test_max_burst();
        test_fifo_full();
        test_valid_gap();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, %0d of %0d passed so far", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-aware write arbiter that shares one synchronous FIFO write port between NREQ requesters.
- Each requester presents a valid/ready/last stream. The arbiter locks the grant to one requester until that packet ends or MAX_BURST beats have been written, then re-arbitrates.
- Sits directly in front of the team's synchronous FIFO. Drives its write enable and data, and is back-pressured by its full flag.

Parameters:
NREQ, 4, number of requesters (>=2)
DWIDTH, 16, data width per requester and of the FIFO write port
MAX_BURST, 8, maximum beats per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*DWIDTH  packed beats, requester i at [i*DWIDTH +: DWIDTH]
req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
fifo_full  input  1  FIFO full flag; treated as authoritative for the current cycle
fifo_wr_en  output  1  FIFO write strobe
fifo_din  output  DWIDTH  FIFO write data
grant_id  output  $clog2(NREQ)  index of the current or most recent grantee
busy  output  1  high while in BURST

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=NREQ-1 (requester 0 has first priority), beat_cnt=0, grant_id=0.
  - Outputs: req_ready=0, fifo_wr_en=0, fifo_din=0, busy=0. Reset mid-burst abandons the packet; no further writes.
- IDLE state:
  - If no req_valid is high, stay in IDLE.
  - Otherwise, search upward from last_grant+1 (modulo NREQ) and take the first valid requester. Register it into grant_id, clear beat_cnt, go to BURST.
  - Arbitration latency is one cycle: no transfer occurs in IDLE.
- BURST state, with g=grant_id:
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - Transfer happens when req_valid[g] && req_ready[g]. In that cycle, fifo_wr_en=1 and fifo_din=req_data[g], both combinational.
  - If there is no transfer, fifo_wr_en=0 and fifo_din=0.
  - beat_cnt increments on each transfer. Its width is $clog2(MAX_BURST+1).
  - Burst termination is evaluated in the transfer cycle. The burst ends if req_last[g]=1 or beat_cnt+1==MAX_BURST.
  - On termination: last_grant<=g, state<=IDLE, busy drops next cycle.
  - One-cycle bubble between grants is required (IDLE re-arbitration).
- Stalls:
  - If req_valid[g]=0 mid-burst, the grant is held and nothing is written. There is no timeout.
  - If fifo_full=1, req_ready[g]=0, so no write occurs and no beat is counted. The grant is held.
- MAX_BURST truncation:
  - The truncated packet's remaining beats continue when the requester next wins.
  - The requester wins again after every other valid requester has had a turn, or immediately if no other requester is valid.
- Fairness: a requester continuously asserting valid waits at most NREQ-1 grants before service.
- grant_id holds its value in IDLE until the next grant is taken.
- Simultaneous events:
  - A new req_valid arriving in the termination cycle is seen in the following IDLE cycle.
  - req_last and the MAX_BURST limit in the same beat cause a single termination.
- Invariants:
  - fifo_wr_en is never high while fifo_full=1.
  - At most one req_ready bit is high.
  - Data order within one requester is preserved.

Test Plan:
- Reset, then req0 sends 3 beats A1,A2,A3 (last on A3), fifo_full=0 -> IDLE 1 cycle, writes on 3 consecutive cycles, busy=1 for 3 cycles, grant_id=0.
- req0 and req2 both hold valid with 2-beat packets -> order is req0 packet, bubble, req2 packet; then req0 again. grant_id sequence 0,2,0.
- MAX_BURST=8, req1 sends a 10-beat packet alone -> 8 writes, 1 idle cycle, 2 writes (last), then IDLE.
- Mid-burst fifo_full=1 for 3 cycles -> req_ready=0 and fifo_wr_en=0 for those 3 cycles, beat_cnt frozen, writes resume the cycle full drops, no beat lost or duplicated.
- Grantee drops req_valid for 2 cycles mid-packet while req3 is valid -> grant not switched, no writes, packet completes before req3 is granted.
- Assert rst during beat 2 of a 4-beat packet -> all outputs 0 immediately; after release, requester 0 has priority and the next grant starts with beat_cnt=0.
